// File: rtl/lsu_ctrl.sv
// lsu_ctrl - multi-cycle load/store unit for the RV32I datapath.
//
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW on behalf of the main control FSM.
// One request is captured in IDLE and then run through a single req/ack
// handshake with data memory. Store data is lane-replicated with matching
// byte enables, and load data is sign/zero extended. Misaligned accesses and
// illegal funct3 codes never reach memory; they complete with err=1.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN):
//   When defined, a REQ that sees no mem_ack for TIMEOUT cycles is abandoned
//   and completes with err=1. When undefined, REQ waits for mem_ack forever.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request strobe, only sampled in IDLE
//   is_store          1 = store, 0 = load
//   funct3            RV32I width/sign field
//   addr              byte address
//   wdata             store data
//   busy              high whenever not in IDLE
//   done              one-cycle completion pulse
//   err               error flag, valid with done, cleared on next accepted start
//   rdata             extended load result, held until the next load completes
//   mem_req/mem_we    memory request / write enable
//   mem_addr          word-aligned address
//   mem_be/mem_wdata  byte enables / lane-replicated write data
//   mem_ack           single-cycle memory completion
//   mem_rdata         read word, valid while mem_ack is high
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic              q_store;
    logic [2:0]        q_f3;
    logic [ADDR_W-1:0] q_addr;
    logic [31:0]       q_wdata;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              legal;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_shifted;
    logic [31:0]       ld_value;
    logic              tmo_hit;

    // Legality is judged on the live inputs so the IDLE decision can skip
    // REQ entirely for a bad access.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~is_store;
            3'b101:  legal = ~is_store & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    // Store lanes: replicate the low byte/half across the word so the
    // enabled lanes always carry the right data whatever the offset.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = q_wdata;
        case (q_f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << q_addr[1:0];
                st_wdata = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << q_addr[1:0];
                st_wdata = {2{q_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = q_wdata;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // A legal word load is always aligned, so the shift is zero for LW.
    always_comb begin
        ld_shifted = mem_rdata >> {q_addr[1:0], 3'b000};
        ld_value   = ld_shifted;
        case (q_f3)
            3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_value = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_value = {16'd0, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts REQ cycles without ack; it sits at zero outside REQ so every
    // REQ entry starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != REQ) begin
            tmo_cnt <= '0;
        end else if (!mem_ack) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Expiry fires in the TIMEOUT-th REQ cycle; an ack in that cycle wins.
    assign tmo_hit = (state == REQ) && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = legal ? REQ : DONE;
            REQ:  if (mem_ack || tmo_hit) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_store <= 1'b0;
            q_f3    <= 3'd0;
            q_addr  <= '0;
            q_wdata <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                q_store <= is_store;
                q_f3    <= funct3;
                q_addr  <= addr;
                q_wdata <= wdata;
                err_q   <= ~legal;
            end
            if (state == REQ && mem_ack && !q_store) begin
                rdata_q <= ld_value;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Memory-side outputs are decoded from state so an asynchronous reset
    // drops mem_req at once, and they read zero outside REQ.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        err       = err_q;
        rdata     = rdata_q;
        mem_req   = (state == REQ);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        if (state == REQ) begin
            mem_we    = q_store;
            mem_addr  = {q_addr[ADDR_W-1:2], 2'b00};
            mem_be    = q_store ? st_be : 4'b1111;
            mem_wdata = q_store ? st_wdata : 32'd0;
        end
    end

endmodule
